// File: rtl/count_check.sv
// count_check: verifies that five 3-bit counter channels each step by exactly +/-1 per clock,
// recording sticky per-channel errors, a saturating error count and the first failing channel.
module count_check #(
  parameter logic [4:0]  DIR_MASK = 5'b00101,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       c_up,
  input  logic [2:0]       c_down,
  input  logic [2:0]       c_up_2,
  input  logic [2:0]       c_down_2,
  input  logic [2:0]       c_down_3,
  output logic [4:0]       err,
  output logic             err_any,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       first_chan,
  output logic             armed
);

  typedef enum logic [1:0] { IDLE = 2'd0, ARM = 2'd1, CHECK = 2'd2 } state_e;

  localparam logic [2:0] NONE = 3'd7;

  function automatic logic [2:0] pop_count(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] idx;
    idx = NONE;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_e           state_q, state_d;
  logic [4:0][2:0]  cur_q, cur_d, prev_q, want_s;
  logic             cur_ok_q, cur_ok_d, prev_ok_q;
  logic             check_s;
  logic [4:0]       fail_s;
  logic [4:0]       err_q, err_d, err_base_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;
  logic [CNT_W+2:0] cnt_sum_s;
  logic [2:0]       first_q, first_d, first_base_s;
  logic             err_any_q, err_any_d, armed_q, armed_d;

  // Next state: dropping en always returns to IDLE so history is re-primed via ARM.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     state_d = CHECK;
        CHECK:   state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  // A pair is only compared once both samples were captured while armed.
  always_comb begin
    cur_d    = {c_down_3, c_down_2, c_up_2, c_down, c_up};
    cur_ok_d = en && (state_q != IDLE);
    check_s  = en && (state_q == CHECK) && prev_ok_q;
    for (int i = 0; i < 5; i++) begin
      want_s[i] = DIR_MASK[i] ? prev_q[i] + 3'd1 : prev_q[i] - 3'd1;
      fail_s[i] = check_s && (cur_q[i] != want_s[i]);
    end
  end

  // Clear is applied before this cycle's violations are folded in.
  always_comb begin
    err_base_s   = clr ? 5'd0 : err_q;
    cnt_base_s   = clr ? {CNT_W{1'b0}} : cnt_q;
    first_base_s = clr ? NONE : first_q;
    err_d        = err_base_s | fail_s;
    cnt_sum_s    = (CNT_W+3)'(cnt_base_s) + (CNT_W+3)'(pop_count(fail_s));
    if (|cnt_sum_s[CNT_W+2:CNT_W]) begin
      cnt_d = {CNT_W{1'b1}};
    end else begin
      cnt_d = cnt_sum_s[CNT_W-1:0];
    end
    if (first_base_s == NONE) begin
      first_d = lowest_idx(fail_s);
    end else begin
      first_d = first_base_s;
    end
    err_any_d = |err_q;
    armed_d   = (state_d == CHECK);
  end

  // State, sample history and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      prev_q    <= '0;
      cur_ok_q  <= 1'b0;
      prev_ok_q <= 1'b0;
      err_q     <= 5'd0;
      cnt_q     <= {CNT_W{1'b0}};
      first_q   <= NONE;
      err_any_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      prev_q    <= cur_q;
      cur_ok_q  <= cur_ok_d;
      prev_ok_q <= cur_ok_q;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      err_any_q <= err_any_d;
      armed_q   <= armed_d;
    end
  end

  assign err        = err_q;
  assign err_any    = err_any_q;
  assign err_cnt    = cnt_q;
  assign first_chan = first_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_count_check.sv
// Scoreboard bench for count_check: the driver pushes expected output snapshots, a negedge
// monitor pops and compares them against the DUT.
module tb_count_check;

  localparam logic [4:0] DIR = 5'b00101;
  localparam int         CW  = 3;

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [2:0]    c_up, c_down, c_up_2, c_down_2, c_down_3;
  logic [4:0]    err;
  logic          err_any;
  logic [CW-1:0] err_cnt;
  logic [2:0]    first_chan;
  logic          armed;

  count_check #(.DIR_MASK(DIR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .c_up(c_up), .c_down(c_down), .c_up_2(c_up_2), .c_down_2(c_down_2), .c_down_3(c_down_3),
    .err(err), .err_any(err_any), .err_cnt(err_cnt), .first_chan(first_chan), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            full;
    logic [4:0]    err;
    logic          err_any;
    logic [CW-1:0] cnt;
    logic [2:0]    fc;
    logic          armed;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  logic [2:0]    val[5];
  logic [2:0]    h1[5];
  logic [2:0]    h2[5];
  int            run;
  logic [4:0]    m_err;
  logic          m_any;
  logic [CW-1:0] m_cnt;
  logic [2:0]    m_fc;
  logic          m_armed;

  function automatic void chk(string nm, string fld, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "err", 8'(err), 8'(e.err));
      chk(e.name, "err_cnt", 8'(err_cnt), 8'(e.cnt));
      chk(e.name, "first_chan", 8'(first_chan), 8'(e.fc));
      chk(e.name, "armed", 8'(armed), 8'(e.armed));
      if (e.full) chk(e.name, "err_any", 8'(err_any), 8'(e.err_any));
    end
  end

  function automatic void model_reset();
    run = 0; m_err = 5'd0; m_any = 1'b0; m_cnt = '0; m_fc = 3'd7; m_armed = 1'b0;
  endfunction

  // Reference: a check at an edge needs en high on that edge and the three before it.
  function automatic void model_edge(input logic e, input logic c);
    logic [4:0] f;
    logic [2:0] want;
    logic       any_old;
    int         n;
    any_old = |m_err;
    run = e ? ((run < 100) ? run + 1 : run) : 0;
    f = 5'd0;
    if (run >= 4) begin
      for (int i = 0; i < 5; i++) begin
        want = DIR[i] ? h2[i] + 3'd1 : h2[i] - 3'd1;
        if (h1[i] !== want) f[i] = 1'b1;
      end
    end
    if (c) begin m_err = 5'd0; m_cnt = '0; m_fc = 3'd7; end
    if (f != 5'd0) begin
      n = 0;
      for (int i = 0; i < 5; i++) if (f[i]) n++;
      m_err = m_err | f;
      if (int'(m_cnt) + n > (1 << CW) - 1) m_cnt = '1;
      else m_cnt = CW'(int'(m_cnt) + n);
      if (m_fc == 3'd7) begin
        for (int i = 4; i >= 0; i--) if (f[i]) m_fc = 3'(i);
      end
    end
    m_any   = any_old;
    m_armed = (run >= 2);
  endfunction

  task automatic cycle(input logic e, input logic c, input logic ar, input logic [4:0] hold);
    exp_t x;
    en = e; clr = c;
    c_up = val[0]; c_down = val[1]; c_up_2 = val[2]; c_down_2 = val[3]; c_down_3 = val[4];
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(e, c);
    if (ar) begin
      #1 rst = 1'b1;
      model_reset();
    end
    for (int i = 0; i < 5; i++) begin
      h2[i] = h1[i];
      h1[i] = val[i];
      if (!hold[i]) val[i] = DIR[i] ? val[i] + 3'd1 : val[i] - 3'd1;
    end
    x.name = phase; x.full = 1'b1; x.err = m_err; x.err_any = m_any;
    x.cnt = m_cnt; x.fc = m_fc; x.armed = m_armed;
    sb.push_back(x);
    #1;
  endtask

  task automatic hand(input logic [4:0] e, input logic [CW-1:0] n, input logic [2:0] fc,
                      input logic a);
    exp_t x;
    x.name = {phase, "_hand"}; x.full = 1'b0; x.err = e; x.err_any = 1'b0;
    x.cnt = n; x.fc = fc; x.armed = a;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    val[0] = 3'd0; val[1] = 3'd0; val[2] = 3'd3; val[3] = 3'd6; val[4] = 3'd1;
    for (int i = 0; i < 5; i++) begin h1[i] = 3'd0; h2[i] = 3'd0; end
    model_reset();

    repeat (2) cycle(1'b0, 1'b0, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b0);
    rst = 1'b0;

    phase = "clean";
    repeat (40) cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b1);

    // c_down_2 presents 4 twice in a row
    phase = "single";
    cycle(1'b1, 1'b0, 1'b0, 5'b01000);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b01000, 3'd1, 3'd3, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b01000, 3'd1, 3'd3, 1'b1);

    phase = "clear";
    cycle(1'b1, 1'b1, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b1);

    // channels 1 and 4 jump by +2, later channel 0 jumps by +4
    phase = "multi";
    val[1] = val[1] + 3'd3; val[4] = val[4] + 3'd3;
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b10010, 3'd2, 3'd1, 1'b1);
    val[0] = val[0] + 3'd3;
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b10011, 3'd3, 3'd1, 1'b1);

    phase = "clr_collide";
    val[2] = val[2] + 3'd3;
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b1, 1'b1, 1'b0, 5'b00000);
    hand(5'b00100, 3'd1, 3'd2, 1'b1);

    phase = "saturate";
    for (int k = 0; k < 10; k++) begin
      val[0] = val[0] + 3'd3;
      cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    end
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b00101, 3'd7, 3'd2, 1'b1);

    phase = "async_rst";
    cycle(1'b1, 1'b0, 1'b1, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    rst = 1'b0;
    phase = "rearm_rst";
    val[1] = val[1] + 3'd5;
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b1);

    phase = "en_gap";
    for (int k = 0; k < 3; k++) begin
      val[0] = val[0] + 3'd2; val[1] = val[1] + 3'd5; val[3] = val[3] + 3'd3;
      cycle(1'b0, 1'b0, 1'b0, 5'b00000);
    end
    hand(5'b00000, 3'd0, 3'd7, 1'b0);
    val[2] = val[2] + 3'd4;
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b00000, 3'd0, 3'd7, 1'b1);
    val[4] = val[4] + 3'd3;
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    hand(5'b10000, 3'd1, 3'd4, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_check.md
# count_check

Runtime checker that sits directly downstream of the five-channel 3-bit counter bank and consumes its outputs (`c_up`, `c_down`, `c_up_2`, `c_down_2`, `c_down_3`). Every clock it compares each channel against the value that channel held on the previous clock. Each channel must step by exactly ±1 modulo 8, in the direction set by a parameter. Any violation is recorded in sticky per-channel error flags, a saturating error counter and a first-failure channel index, for board-level self-test and debug.

## Interface
Parameters:
- `DIR_MASK`, default `5'b00101`: per-channel expected direction. Bit i = 1 means up (+1 mod 8), 0 means down (−1 mod 8). Channel order is 0 `c_up`, 1 `c_down`, 2 `c_up_2`, 3 `c_down_2`, 4 `c_down_3`.
- `CNT_W`, default `8`: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  checking enable; level-sensitive.
- `clr`  in  1  synchronous clear of the error state; single-cycle pulse.
- `c_up`  in  3  channel 0 input.
- `c_down`  in  3  channel 1 input.
- `c_up_2`  in  3  channel 2 input.
- `c_down_2`  in  3  channel 3 input.
- `c_down_3`  in  3  channel 4 input.
- `err`  out  5  sticky per-channel error flags.
- `err_any`  out  1  OR of `err`, registered.
- `err_cnt`  out  CNT_W  total violations; saturates at all-ones.
- `first_chan`  out  3  lowest-index channel of the first violation. `3'd7` = none.
- `armed`  out  1  high while state = CHECK.

## Operation
- **Input stage:** all five inputs are registered into `cur` every clock, unconditionally. The previous `cur` moves to `prev`.
- **State machine:**
  - IDLE: entered on reset, or whenever `en` = 0. No checks are performed.
  - IDLE → ARM when `en` = 1. ARM lasts exactly one cycle and only fills `prev`/`cur`; no check.
  - ARM → CHECK when `en` = 1. ARM or CHECK → IDLE whenever `en` = 0.
  - Re-asserting `en` always passes through ARM again, so stale history is never compared.
- **Check (CHECK state only):**
  - Channel i fails if `cur[i] != prev[i] + 1` (up) or `cur[i] != prev[i] - 1` (down).
  - Arithmetic is 3-bit modulo: 7→0 is a legal up step, 0→7 is a legal down step.
  - A held value (no change) is a failure.
- **On violations in a cycle:**
  - Set `err[i]` for every failing channel.
  - Increment `err_cnt` by the number of failing channels (1–5) in that cycle, saturating.
  - If `first_chan` = 7, load it with the lowest failing index.
- **Clear:** `clr` = 1 resets `err`, `err_cnt` and `first_chan` to their reset values. If a violation is detected in the same cycle as `clr`, clear happens first and that violation is then recorded: `err` holds only the new bits, `err_cnt` = number of new failures, `first_chan` = lowest new index.
- **`clr` and the state machine:** `clr` does not affect the state machine or the `prev`/`cur` history.
- **Reset values:**
  - `err` = 0, `err_any` = 0, `err_cnt` = 0, `first_chan` = 7, `armed` = 0.
  - State = IDLE; `prev`/`cur` = 0.
  - Asynchronous reset mid-CHECK discards history. After reset release with `en` = 1, the block passes through IDLE → ARM → CHECK before it checks again.

## Timing
- Input value present before edge k is captured into `cur` at edge k.
- Its check result is registered at edge k+1. Total latency from bad input to `err`/`err_cnt`/`first_chan` = 2 edges.
- `err_any` lags `err` by one further edge.
- From reset release with `en` held high:
  - edge 1: IDLE→ARM.
  - edge 2: ARM→CHECK; `armed` = 1 after edge 2.
  - First checked pair = the samples at edges 2 and 3; result visible after edge 4.
- `en` deasserted before edge k: state = IDLE after edge k. A check pending at edge k (pair from edges k−2/k−1) is suppressed.
- `err_cnt` at all-ones stays all-ones on further violations; no wrap.

## Test plan
- **Clean run:** `DIR_MASK` default, all channels stepping correctly with wraps (7→0 up, 0→7 down) for 40 cycles → `err` = 0, `err_cnt` = 0, `first_chan` = 7, `armed` = 1 from cycle 2.
- **Single fault:** force `c_down_2` to hold 3'd4 for two samples → `err` = 5'b01000, `err_cnt` = 1, `first_chan` = 3, visible 2 edges after the repeated sample, and sticky thereafter.
- **Multi-fault same cycle:** channels 1 and 4 jump by +2 in one sample → `err` = 5'b10010, `err_cnt` += 2, `first_chan` = 1. A later fault on channel 0 leaves `first_chan` = 1.
- **Clear collision:** `clr` pulsed in the same cycle a channel 2 fault is detected → `err` = 5'b00100, `err_cnt` = 1, `first_chan` = 2.
- **Saturation:** `CNT_W` = 3, inject 10 single faults → `err_cnt` = 7 and holds.
- **Reset / enable re-arm:** assert `rst` mid-CHECK with `err` set → all outputs at reset values immediately. Toggle `en` low for 3 cycles while the inputs jump arbitrarily, then high → no error reported across the gap; checking resumes 2 edges after `en` rises.
